// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and counter sizing.
package uart_pkg;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receiver state encoding (kept as plain constants for legacy tooling).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Width of the per-bit clock counter; never narrower than one bit.
  function automatic int cnt_width(input int clk_per_bit);
    return (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: a two-flop synchroniser for the
// asynchronous line, followed by a 3-deep history used for a 2-of-3 majority
// vote. Every flop resets to 1 so the idle-high line never looks like a start.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic rx_major_o
);

  logic       meta_q;
  logic       sync_q;
  logic [2:0] hist_q;

  // Two-flop synchroniser bringing the line into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  // Three most recent synchronised samples feeding the majority vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], sync_q};
    end
  end

  assign rx_sync_o  = sync_q;
  assign rx_major_o = (hist_q[0] & hist_q[1]) |
                      (hist_q[0] & hist_q[2]) |
                      (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional odd or
// even parity, one or two stop bits. Each bit is judged by a 2-of-3 majority
// vote around its centre. Every character, good or bad, is delivered with a
// one-cycle o_valid strobe together with framing, parity and break flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break
);

  localparam int CNT_W = cnt_width(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = (CLK_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  // Conditioned line.
  logic rx_sync;
  logic rx_major;

  // Falling-edge detector on the synchronised line.
  logic rx_prev_q;
  logic fall_q;

  // Receiver state and datapath.
  logic [2:0]           state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [IDX_W-1:0]     idx_q,        idx_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                 par_bit_q,    par_bit_d;
  logic                 frame_pend_q, frame_pend_d;
  logic                 stop0_low_q,  stop0_low_d;

  // Registered character outputs.
  logic [DATA_BITS-1:0] data_q,       data_d;
  logic                 valid_q,      valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 par_err_q,    par_err_d;
  logic                 brk_q,        brk_d;

  // Helpers evaluated at the final stop sample.
  logic bit_tick;
  logic par_xor;
  logic parity_bad;
  logic first_stop_low;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (i_rx),
    .rx_sync_o  (rx_sync),
    .rx_major_o (rx_major)
  );

  // Registered 1->0 detector; a line held low produces no further pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      rx_prev_q <= rx_sync;
      fall_q    <= rx_prev_q & ~rx_sync;
    end
  end

  assign bit_tick = (cnt_q == CNT_FULL);
  assign par_xor  = (^shreg_q) ^ par_bit_q;

  // Odd parity expects an odd number of ones across data and parity bit.
  assign parity_bad = (PARITY == PAR_ODD)  ? ~par_xor :
                      (PARITY == PAR_EVEN) ?  par_xor : 1'b0;

  // With one stop bit the first stop sample is the one being taken now.
  assign first_stop_low = (idx_q == '0) ? ~rx_major : stop0_low_q;

  // Next-state logic: sampling schedule, data capture and character delivery.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    frame_pend_d = frame_pend_q;
    stop0_low_d  = stop0_low_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
    par_err_d    = par_err_q;
    brk_d        = brk_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d        = '0;
        idx_d        = '0;
        par_bit_d    = 1'b0;
        frame_pend_d = 1'b0;
        if (fall_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          // A start bit that is high again at its centre was only a glitch.
          state_d = rx_major ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shreg_d = {rx_major, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_bit_d = rx_major;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            stop0_low_d = ~rx_major;
          end
          if (!rx_major) begin
            frame_pend_d = 1'b1;
          end
          if (idx_q == IDX_LAST_STOP) begin
            // Leave mid-stop-bit so the next start edge is caught in IDLE.
            idx_d       = '0;
            state_d     = ST_IDLE;
            valid_d     = 1'b1;
            data_d      = shreg_q;
            frame_err_d = frame_pend_q | ~rx_major;
            par_err_d   = parity_bad;
            brk_d       = (shreg_q == '0) &&
                          ((PARITY == PAR_NONE) || !par_bit_q) &&
                          first_stop_low;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      frame_pend_q <= 1'b0;
      stop0_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      frame_pend_q <= frame_pend_d;
      stop0_low_q  <= stop0_low_d;
    end
  end

  // Character outputs; held between strobes, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      brk_q       <= brk_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = par_err_q;
  assign o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8O2) at 16 clocks per
// bit. Characters are built as wire-level bit vectors and the expected result
// is derived from the wire bits by a small reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct packed {
    logic [7:0]  data;
    logic        fe;
    logic        pe;
    logic        brk;
    logic [31:0] cyc;
  } rec_t;

  // Per-instance configuration: 0 = 8N1, 1 = 8E1, 2 = 8O2.
  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx      [3];
  logic [7:0] data_o  [3];
  logic       valid_o [3];
  logic       busy_o  [3];
  logic       fe_o    [3];
  logic       pe_o    [3];
  logic       brk_o   [3];

  logic [31:0] cyc = '0;
  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];

  int n_vec = 0;
  int n_err = 0;

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .i_rx(rx[0]), .o_data(data_o[0]), .o_valid(valid_o[0]),
    .o_busy(busy_o[0]), .o_frame_err(fe_o[0]), .o_parity_err(pe_o[0]), .o_break(brk_o[0]));

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .i_rx(rx[1]), .o_data(data_o[1]), .o_valid(valid_o[1]),
    .o_busy(busy_o[1]), .o_frame_err(fe_o[1]), .o_parity_err(pe_o[1]), .o_break(brk_o[1]));

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_o2 (
    .clk(clk), .rst(rst), .i_rx(rx[2]), .o_data(data_o[2]), .o_valid(valid_o[2]),
    .o_busy(busy_o[2]), .o_frame_err(fe_o[2]), .o_parity_err(pe_o[2]), .o_break(brk_o[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which o_valid is high, away from the active edge.
  always @(negedge clk) begin
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      if (valid_o[i] === 1'b1) begin
        r.data = data_o[i];
        r.fe   = fe_o[i];
        r.pe   = pe_o[i];
        r.brk  = brk_o[i];
        r.cyc  = cyc;
        case (i)
          0:       q0.push_back(r);
          1:       q1.push_back(r);
          default: q2.push_back(r);
        endcase
      end
    end
  end

  function automatic int qsize(input int w);
    case (w)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic rec_t qpop(input int w);
    case (w)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    n_vec++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wire-level frame: start, 8 data bits LSB first, optional parity, stops.
  function automatic void build(input logic [7:0] d, input int pm, input int sb,
                                input bit flip_p, input logic [1:0] stop_lv,
                                output logic [15:0] fb, output int len);
    int   ones;
    logic p;
    ones = $countones(d);
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
    len = 9;
    if (pm != 0) begin
      p = (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      fb[len] = p ^ flip_p;
      len++;
    end
    for (int s = 0; s < sb; s++) begin
      fb[len] = stop_lv[s];
      len++;
    end
  endfunction

  // Reference model: what the receiver must report for a given wire frame.
  function automatic rec_t model(input logic [15:0] fb, input int pm, input int sb);
    rec_t r;
    int   ones;
    int   pos;
    logic p;
    r    = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r.data[i] = fb[1 + i];
      if (fb[1 + i]) ones++;
    end
    pos = 9;
    p   = 1'b0;
    if (pm != 0) begin
      p = fb[pos];
      pos++;
      if (p) ones++;
      r.pe = (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    for (int s = 0; s < sb; s++) begin
      if (!fb[pos + s]) r.fe = 1'b1;
    end
    r.brk = (r.data == 8'h00) && !p && !fb[pos];
    return r;
  endfunction

  function automatic int exp_lat(input int pm, input int sb);
    return 2 + 3 + HALF + (8 + ((pm != 0) ? 1 : 0) + sb) * CPB + 1;
  endfunction

  // Drive a frame bit by bit; optional 1-cycle inversion at each bit centre.
  task automatic send_bits(input int w, input logic [15:0] fb, input int len, input bit spikes);
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rx[w] = (spikes && c == CPB / 2 - 1) ? ~fb[b] : fb[b];
        tick(1);
      end
    end
  endtask

  task automatic expect_char(input int w, input int start, input rec_t e, input string tag);
    rec_t r;
    int   waited;
    waited = 0;
    while (qsize(w) == 0 && waited < 4 * CPB) begin
      tick(1);
      waited++;
    end
    check({tag, "_valid"}, 32'(qsize(w) != 0), 32'd1);
    if (qsize(w) != 0) begin
      r = qpop(w);
      check({tag, "_data"}, 32'(r.data), 32'(e.data));
      check({tag, "_frame"}, 32'(r.fe), 32'(e.fe));
      check({tag, "_parity"}, 32'(r.pe), 32'(e.pe));
      check({tag, "_break"}, 32'(r.brk), 32'(e.brk));
      check_near({tag, "_latency"}, int'(r.cyc) - start, exp_lat(cfg_par[w], cfg_stop[w]), 1);
    end
  endtask

  // Full character: send, idle one bit high, compare, confirm a single strobe.
  task automatic char_test(input int w, input logic [7:0] d, input bit flip_p,
                           input logic [1:0] stop_lv, input bit spikes, input string tag);
    logic [15:0] fb;
    int          len;
    int          start;
    rec_t        e;
    build(d, cfg_par[w], cfg_stop[w], flip_p, stop_lv, fb, len);
    e     = model(fb, cfg_par[w], cfg_stop[w]);
    start = int'(cyc);
    send_bits(w, fb, len, spikes);
    rx[w] = 1'b1;
    tick(CPB);
    expect_char(w, start, e, tag);
    check({tag, "_single"}, 32'(qsize(w)), 32'd0);
  endtask

  initial begin
    logic [15:0] fb;
    logic [15:0] fb2;
    int          len;
    int          len2;
    int          start;
    int          start2;
    rec_t        e;
    rec_t        e2;

    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    rst = 1'b1;
    tick(3);

    // Reset state of every instance.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_data%0d", i),  32'(data_o[i]),  32'd0);
      check($sformatf("rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
      check($sformatf("rst_busy%0d", i),  32'(busy_o[i]),  32'd0);
      check($sformatf("rst_fe%0d", i),    32'(fe_o[i]),    32'd0);
      check($sformatf("rst_pe%0d", i),    32'(pe_o[i]),    32'd0);
      check($sformatf("rst_brk%0d", i),   32'(brk_o[i]),   32'd0);
    end
    rst = 1'b0;
    tick(2 * CPB);

    // 8N1 basic character with latency.
    char_test(0, 8'hA5, 1'b0, 2'b11, 1'b0, "n1_a5");

    // 8E1: correct parity, then corrupted parity.
    char_test(1, 8'hA5, 1'b0, 2'b11, 1'b0, "e1_a5_ok");
    char_test(1, 8'hA5, 1'b1, 2'b11, 1'b0, "e1_a5_perr");

    // 8O2: second stop bit low, then a clean character.
    char_test(2, 8'h3C, 1'b0, 2'b01, 1'b0, "o2_stop2_low");
    tick(CPB);
    char_test(2, 8'h55, 1'b0, 2'b11, 1'b0, "o2_55");

    // 8N1: line held low for 20 bit times -> one break character only.
    fb    = '0;
    e     = model(fb, 0, 1);
    start = int'(cyc);
    rx[0] = 1'b0;
    tick(20 * CPB);
    expect_char(0, start, e, "n1_hold_low");
    check("n1_hold_low_no_retrigger", 32'(qsize(0)), 32'd0);
    rx[0] = 1'b1;
    tick(3 * CPB);
    check("n1_after_release", 32'(qsize(0)), 32'd0);

    // 8N1: 0.3-bit glitch is a false start.
    rx[0] = 1'b0;
    tick(5);
    check("glitch_busy_high", 32'(busy_o[0]), 32'd1);
    rx[0] = 1'b1;
    tick(2 * CPB);
    check("glitch_busy_low", 32'(busy_o[0]), 32'd0);
    check("glitch_no_valid", 32'(qsize(0)), 32'd0);

    // 8N1: single-cycle spikes at every bit centre are voted out.
    char_test(0, 8'h81, 1'b0, 2'b11, 1'b1, "n1_spike_81");
    tick(CPB);

    // 8N1: reset in the middle of data bit 4 of 0xFF.
    build(8'hFF, 0, 1, 1'b0, 2'b11, fb, len);
    send_bits(0, fb, 5, 1'b0);
    rx[0] = fb[5];
    tick(CPB / 2);
    check("midrst_busy_before", 32'(busy_o[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_data",  32'(data_o[0]),  32'd0);
    check("midrst_valid", 32'(valid_o[0]), 32'd0);
    check("midrst_busy",  32'(busy_o[0]),  32'd0);
    check("midrst_fe",    32'(fe_o[0]),    32'd0);
    check("midrst_pe",    32'(pe_o[0]),    32'd0);
    check("midrst_brk",   32'(brk_o[0]),   32'd0);
    rx[0] = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2 * CPB);
    check("midrst_no_valid", 32'(qsize(0)), 32'd0);

    // 8N1: back-to-back 0x12 and 0x34 with no idle gap.
    build(8'h12, 0, 1, 1'b0, 2'b11, fb, len);
    build(8'h34, 0, 1, 1'b0, 2'b11, fb2, len2);
    e      = model(fb, 0, 1);
    e2     = model(fb2, 0, 1);
    start  = int'(cyc);
    send_bits(0, fb, len, 1'b0);
    start2 = int'(cyc);
    send_bits(0, fb2, len2, 1'b0);
    rx[0] = 1'b1;
    tick(CPB);
    expect_char(0, start, e, "b2b_12");
    expect_char(0, start2, e2, "b2b_34");
    check("b2b_count", 32'(qsize(0)), 32'd0);

    // Randomised characters on all three configurations.
    for (int i = 0; i < 12; i++) begin
      int         w;
      logic [7:0] d;
      bit         flip;
      logic [1:0] stops;
      w     = i % 3;
      d     = 8'($urandom);
      if (i % 4 == 3) d = 8'h00;
      flip  = (cfg_par[w] != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      char_test(w, d, flip, stops, 1'b0, $sformatf("rand%0d", i));
      tick(CPB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
